// File: rtl/count_mon_pkg.sv
// rtl/count_mon_pkg.sv - shared types and defaults for the count direction monitor
package count_mon_pkg;

  localparam int DEF_WIDTH    = 4;
  localparam int DEF_LOCK_CNT = 3;
  localparam int DEF_ERR_W    = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACQUIRE,
    LOCKED
  } state_t;

  typedef enum logic [1:0] {
    D_HOLD,
    D_UP,
    D_DOWN,
    D_JUMP
  } delta_t;

endpackage

// File: rtl/count_delta_classify.sv
// rtl/count_delta_classify.sv - classifies the modular difference between two count samples
module count_delta_classify
  import count_mon_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] count_in,
  input  logic [WIDTH-1:0] prev,
  output delta_t           delta
);

  logic [WIDTH-1:0] diff;

  // Subtraction stays at WIDTH bits so counter wrap appears as a +1/-1 step.
  assign diff = count_in - prev;

  always_comb begin
    delta = D_JUMP;
    if (diff == '0) begin
      delta = D_HOLD;
    end else if (diff == WIDTH'(1)) begin
      delta = D_UP;
    end else if (diff == '1) begin
      delta = D_DOWN;
    end
  end

endmodule

// File: rtl/count_direction_decoder.sv
// rtl/count_direction_decoder.sv - recovers direction, steps, stalls and jumps from a counter bus
module count_direction_decoder
  import count_mon_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int LOCK_CNT = DEF_LOCK_CNT,
  parameter int ERR_W    = DEF_ERR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] count_in,
  input  logic             count_valid,
  output logic             dir_up,
  output logic             step,
  output logic             hold,
  output logic             reversal,
  output logic             err_jump,
  output logic             locked,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [3:0] LOCK_V = 4'(LOCK_CNT);

  state_t           state, state_next;
  logic [WIDTH-1:0] prev, prev_next;
  logic [3:0]       acq_cnt, acq_next;
  logic             dir_next;
  logic [ERR_W-1:0] err_next;
  logic             step_next, hold_next, rev_next, jump_next;
  logic             new_up;
  delta_t           delta;

  count_delta_classify #(.WIDTH(WIDTH)) u_classify (
    .count_in (count_in),
    .prev     (prev),
    .delta    (delta)
  );

  assign new_up = (delta == D_UP);
  assign locked = (state == LOCKED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      prev      <= '0;
      acq_cnt   <= '0;
      dir_up    <= 1'b1;
      err_count <= '0;
      step      <= 1'b0;
      hold      <= 1'b0;
      reversal  <= 1'b0;
      err_jump  <= 1'b0;
    end else begin
      state     <= state_next;
      prev      <= prev_next;
      acq_cnt   <= acq_next;
      dir_up    <= dir_next;
      err_count <= err_next;
      step      <= step_next;
      hold      <= hold_next;
      reversal  <= rev_next;
      err_jump  <= jump_next;
    end
  end

  always_comb begin
    state_next = state;
    prev_next  = prev;
    acq_next   = acq_cnt;
    dir_next   = dir_up;
    err_next   = err_count;
    step_next  = 1'b0;
    hold_next  = 1'b0;
    rev_next   = 1'b0;
    jump_next  = 1'b0;

    if (count_valid) begin
      // prev follows every sample so re-acquisition starts from a jump target.
      prev_next = count_in;
      case (state)
        IDLE: begin
          state_next = ACQUIRE;
          acq_next   = '0;
        end
        ACQUIRE: begin
          case (delta)
            D_UP, D_DOWN: begin
              step_next = 1'b1;
              dir_next  = new_up;
              acq_next  = (new_up != dir_up) ? 4'd1 : acq_cnt + 4'd1;
              if (acq_next >= LOCK_V) begin
                state_next = LOCKED;
              end
            end
            D_HOLD: hold_next = 1'b1;
            default: begin
              jump_next = 1'b1;
              err_next  = (err_count == '1) ? err_count : err_count + ERR_W'(1);
              acq_next  = '0;
            end
          endcase
        end
        LOCKED: begin
          case (delta)
            D_UP, D_DOWN: begin
              step_next = 1'b1;
              rev_next  = (new_up != dir_up);
              dir_next  = new_up;
            end
            D_HOLD: hold_next = 1'b1;
            default: begin
              jump_next  = 1'b1;
              err_next   = (err_count == '1) ? err_count : err_count + ERR_W'(1);
              acq_next   = '0;
              state_next = ACQUIRE;
            end
          endcase
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_count_direction_decoder.sv
// tb/tb_count_direction_decoder.sv - scoreboard bench for count_direction_decoder
module tb_count_direction_decoder;

  localparam int LOCK_CNT = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       count_valid = 1'b0;
  logic [3:0] count_in = 4'd0;

  logic       dir_up, step, hold, reversal, err_jump, locked;
  logic [7:0] err_count;
  logic       dir_up_b, step_b, hold_b, reversal_b, err_jump_b, locked_b;
  logic [1:0] err_count_b;

  always #5 clk = ~clk;

  count_direction_decoder #(.WIDTH(4), .LOCK_CNT(LOCK_CNT), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .count_in(count_in), .count_valid(count_valid),
    .dir_up(dir_up), .step(step), .hold(hold), .reversal(reversal),
    .err_jump(err_jump), .locked(locked), .err_count(err_count)
  );

  count_direction_decoder #(.WIDTH(4), .LOCK_CNT(LOCK_CNT), .ERR_W(2)) dut_sat (
    .clk(clk), .rst(rst), .count_in(count_in), .count_valid(count_valid),
    .dir_up(dir_up_b), .step(step_b), .hold(hold_b), .reversal(reversal_b),
    .err_jump(err_jump_b), .locked(locked_b), .err_count(err_count_b)
  );

  typedef struct {
    logic dir_up, step, hold, reversal, err_jump, locked;
    int   err8, err2;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int errors = 0;
  int checks = 0;

  // Reference model: tracks the last sample and the run of consistent steps.
  bit m_have, m_locked, m_dir;
  int m_prev, m_run, m_err8, m_err2;

  function automatic exp_t model(input bit r, input bit v, input int c);
    exp_t e;
    int d;
    bit nd;
    e = '{default: 0};
    if (r) begin
      m_have = 0; m_locked = 0; m_dir = 1; m_prev = 0; m_run = 0; m_err8 = 0; m_err2 = 0;
    end else if (v) begin
      if (!m_have) begin
        m_have = 1;
        m_run  = 0;
      end else begin
        d = (c - m_prev) & 15;
        if (d == 1 || d == 15) begin
          nd = (d == 1);
          e.step = 1;
          if (m_locked) begin
            e.reversal = (nd != m_dir);
          end else begin
            m_run = (nd != m_dir) ? 1 : m_run + 1;
            if (m_run >= LOCK_CNT) m_locked = 1;
          end
          m_dir = nd;
        end else if (d == 0) begin
          e.hold = 1;
        end else begin
          e.err_jump = 1;
          m_err8 = (m_err8 < 255) ? m_err8 + 1 : 255;
          m_err2 = (m_err2 < 3) ? m_err2 + 1 : 3;
          m_locked = 0;
          m_run = 0;
        end
      end
      m_prev = c;
    end
    e.dir_up = m_dir;
    e.locked = m_locked;
    e.err8   = m_err8;
    e.err2   = m_err2;
    return e;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input bit r, input bit v, input int c);
    @(negedge clk);
    rst = r;
    count_valid = v;
    count_in = 4'(c);
    q.push_back(model(r, v, c));
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      check("dir_up",     32'(dir_up),      32'(mon_e.dir_up));
      check("step",       32'(step),        32'(mon_e.step));
      check("hold",       32'(hold),        32'(mon_e.hold));
      check("reversal",   32'(reversal),    32'(mon_e.reversal));
      check("err_jump",   32'(err_jump),    32'(mon_e.err_jump));
      check("locked",     32'(locked),      32'(mon_e.locked));
      check("err_count",  32'(err_count),   32'(mon_e.err8));
      check("sat_locked", 32'(locked_b),    32'(mon_e.locked));
      check("sat_jump",   32'(err_jump_b),  32'(mon_e.err_jump));
      check("sat_err",    32'(err_count_b), 32'(mon_e.err2));
    end
  end

  initial begin
    int seq[];
    int cur;
    bit up;
    int k;
    // -1 marks a reset edge with count_valid held high.
    seq = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 0, 1,
            2, 3, 4, 5, 4, 3, 4, 5, 6, 7, 12, 11, 10, 9,
            0, 5, 10, 0, 5, 6, 7, 8, 9, 9, -1, 10, 11, 12, 13};
    drive(1, 0, 0);
    drive(1, 1, 7);
    foreach (seq[i]) begin
      if (seq[i] < 0) drive(1, 1, 3);
      else drive(0, 1, seq[i]);
    end
    drive(0, 0, 4);

    cur = 13;
    up = 1;
    for (int n = 0; n < 600; n++) begin
      k = $urandom_range(0, 19);
      if (k == 0) begin
        drive(1, $urandom_range(0, 1), $urandom_range(0, 15));
      end else if (k < 3) begin
        drive(0, 0, $urandom_range(0, 15));
      end else if (k < 5) begin
        drive(0, 1, cur);
      end else if (k < 7) begin
        cur = $urandom_range(0, 15);
        drive(0, 1, cur);
      end else begin
        if ($urandom_range(0, 7) == 0) up = ~up;
        cur = up ? (cur + 1) & 15 : (cur + 15) & 15;
        drive(0, 1, cur);
      end
    end

    drive(0, 0, 0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #3;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
